// File: rtl/lamp_sequencer.sv
// Traffic lamp sequencer: RED -> GREEN -> YELLOW cycle with pedestrian early exit,
// pedestrian grant on RED entry, and an emergency override that parks the lamps on RED.
module lamp_sequencer #(
  parameter int unsigned RED_T     = 8,
  parameter int unsigned GREEN_T   = 6,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned MIN_GREEN = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ped_req,
  input  logic             emergency,
  output logic [0:2]       light,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] elapsed,
  output logic             ped_ack,
  output logic             walk
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_EMERG  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_RED_LAST    = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] L_GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] L_YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_MIN_LAST    = CNT_W'(MIN_GREEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_elapsed;
  logic             r_ped_pending;
  logic             r_ped_ack;
  logic             r_walk;
  logic             r_emerg_pend;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RED;
      r_elapsed     <= '0;
      r_ped_pending <= 1'b0;
      r_ped_ack     <= 1'b0;
      r_walk        <= 1'b0;
      r_emerg_pend  <= 1'b0;
    end else begin
      r_ped_ack <= 1'b0;
      if (ped_req)
        r_ped_pending <= 1'b1;
      unique case (r_state)
        S_RED: begin
          if (emergency) begin
            r_state   <= S_EMERG;
            r_elapsed <= '0;
            r_walk    <= 1'b0;
          end else if (enable) begin
            if (r_elapsed == L_RED_LAST) begin
              r_state   <= S_GREEN;
              r_elapsed <= '0;
              r_walk    <= 1'b0;
            end else begin
              r_elapsed <= r_elapsed + 1'b1;
            end
          end
        end
        S_GREEN: begin
          if (emergency) begin
            r_state      <= S_YELLOW;
            r_elapsed    <= '0;
            r_emerg_pend <= 1'b1;
          end else if (enable) begin
            if ((r_ped_pending && (r_elapsed >= L_MIN_LAST)) ||
                (r_elapsed == L_GREEN_LAST)) begin
              r_state   <= S_YELLOW;
              r_elapsed <= '0;
            end else begin
              r_elapsed <= r_elapsed + 1'b1;
            end
          end
        end
        S_YELLOW: begin
          // Once emergency is seen, yellow runs to completion even if enable drops.
          if (emergency || r_emerg_pend) begin
            if (r_elapsed == L_YELLOW_LAST) begin
              r_state      <= S_EMERG;
              r_elapsed    <= '0;
              r_emerg_pend <= 1'b0;
            end else begin
              r_elapsed    <= r_elapsed + 1'b1;
              r_emerg_pend <= 1'b1;
            end
          end else if (enable) begin
            if (r_elapsed == L_YELLOW_LAST) begin
              r_state   <= S_RED;
              r_elapsed <= '0;
              if (r_ped_pending) begin
                r_ped_ack     <= 1'b1;
                r_walk        <= 1'b1;
                r_ped_pending <= ped_req;
              end
            end else begin
              r_elapsed <= r_elapsed + 1'b1;
            end
          end
        end
        S_EMERG: begin
          if (!emergency) begin
            r_state   <= S_RED;
            r_elapsed <= '0;
            if (r_ped_pending) begin
              r_ped_ack     <= 1'b1;
              r_walk        <= 1'b1;
              r_ped_pending <= ped_req;
            end
          end else if (r_elapsed != '1) begin
            r_elapsed <= r_elapsed + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    light = 3'b100;
    unique case (r_state)
      S_RED:    light = 3'b100;
      S_GREEN:  light = 3'b010;
      S_YELLOW: light = 3'b001;
      S_EMERG:  light = 3'b100;
    endcase
  end

  assign phase   = r_state;
  assign elapsed = r_elapsed;
  assign ped_ack = r_ped_ack;
  assign walk    = r_walk;

endmodule

// File: doc/lamp_sequencer.md
LAMP_SEQUENCER -- requirements
Module: lamp_sequencer

Interface
REQ-001 Parameter RED_T, default 8: RED dwell in enabled cycles; legal range 1..2^CNT_W-1.
REQ-002 Parameter GREEN_T, default 6: GREEN dwell in enabled cycles; legal range 1..2^CNT_W-1.
REQ-003 Parameter YELLOW_T, default 2: YELLOW dwell in enabled cycles; legal range 1..2^CNT_W-1.
REQ-004 Parameter MIN_GREEN, default 2: minimum GREEN cycles before a pedestrian cut; legal range 1..GREEN_T.
REQ-005 Parameter CNT_W, default 8: width of the elapsed counter.
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  high: the phase timer advances; low: state and timer freeze (except as REQ-019 allows).
REQ-009 ped_req  in  1  pedestrian request, level, sampled each rising edge.
REQ-010 emergency  in  1  emergency override, level, sampled each rising edge.
REQ-011 light  out  [0:2]  lamp drive: RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
REQ-012 phase  out  2  current state encoding.
REQ-013 elapsed  out  CNT_W  cycles spent in the current state.
REQ-014 ped_ack  out  1  one-cycle pulse: pedestrian request granted.
REQ-015 walk  out  1  pedestrian crossing permitted.

Function
REQ-016 States: S_RED=0, S_GREEN=1, S_YELLOW=2, S_EMERG=3; normal cycle is RED->GREEN->YELLOW->RED.
REQ-017 Light decode (combinational, from state): S_RED and S_EMERG->100; S_GREEN->010; S_YELLOW->001.
REQ-018 elapsed is cleared on every state entry and increments on each enabled cycle; a state is exited at the edge where elapsed==dwell-1 and enable=1, so each state lasts exactly dwell enabled cycles.
REQ-019 enable=0 freezes state and elapsed, except that emergency handling (REQ-023..026) ignores enable.
REQ-020 ped_req=1 at an edge sets the internal flag ped_pending; ped_pending stays set until it is granted.
REQ-021 GREEN early exit: in S_GREEN with ped_pending=1, enable=1 and elapsed>=MIN_GREEN-1, the block moves to S_YELLOW at that edge.
REQ-022 Grant: on any edge entering S_RED with ped_pending=1, the block pulses ped_ack for 1 cycle, clears ped_pending, and sets walk=1 until S_RED is left; ped_req present at that same edge is re-latched and served on the next RED.
REQ-023 Emergency from S_GREEN: emergency=1 forces S_YELLOW at the next edge, with elapsed cleared.
REQ-024 Emergency from S_YELLOW: the yellow dwell completes, advancing every cycle regardless of enable, then the block enters S_EMERG.
REQ-025 Emergency from S_RED: the block enters S_EMERG at the next edge and walk is cleared.
REQ-026 S_EMERG holds (light=100, walk=0, no ped_ack) while emergency=1; emergency=0 moves the block to S_RED with a full RED_T dwell, and a pending request is granted on that entry.
REQ-027 Priority: emergency > pedestrian early exit > dwell expiry.
REQ-028 elapsed saturates at 2^CNT_W-1 in S_EMERG.

Reset
REQ-029 reset_n=0 forces immediately, without a clock: state=S_RED, elapsed=0, light=100, phase=0, ped_pending=0, ped_ack=0, walk=0.
REQ-030 After reset_n rises, the first RED lasts a full RED_T enabled cycles.

Verification (default parameters)
REQ-031 Free run: reset, then enable=1 -> light 100 for 8 cycles, 010 for 6, 001 for 2, period 16, ped_ack never asserted.
REQ-032 Pedestrian: ped_req pulse during RED -> GREEN lasts 2 cycles, YELLOW 2, then at RED entry ped_ack=1 for 1 cycle and walk=1 for 8 cycles.
REQ-033 Freeze: enable=0 for 5 cycles at GREEN elapsed=3 -> light stays 010 and elapsed stays 3; total GREEN = 6 enabled cycles.
REQ-034 Emergency: assert at GREEN elapsed=3 with enable=0 -> YELLOW for 2 cycles, then S_EMERG (100) held; deassert -> RED for a full 8 cycles.
REQ-035 Reset mid-YELLOW: drop reset_n between edges -> light=100, walk=0 and pending cleared without a clock edge.
REQ-036 Simultaneous events: ped_req together with emergency during GREEN -> emergency path taken; ped_ack fires at the RED entry after S_EMERG.
